// File: rtl/key_conditioner.sv
// Conditions N asynchronous board inputs: synchronise, fix polarity, debounce on a shared tick,
// and report level, edge pulses, optional auto-repeat presses, sticky flags and a masked IRQ.
module key_conditioner #(
  parameter int             N              = 3,
  parameter logic [N-1:0]   INVERT         = '1,
  parameter int             PRESCALE       = 500,
  parameter int             DEBOUNCE_TICKS = 4,
  parameter int             REPEAT_EN      = 0,
  parameter int             REPEAT_DELAY   = 50,
  parameter int             REPEAT_PERIOD  = 10
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  input  logic [N-1:0] raw_in,
  input  logic [N-1:0] clr,
  input  logic [N-1:0] irq_en,
  output logic [N-1:0] level,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] press,
  output logic [N-1:0] sticky,
  output logic         irq
);

  localparam int PW     = $clog2(PRESCALE) + 1;
  localparam int DW     = $clog2(DEBOUNCE_TICKS) + 1;
  localparam int HW     = $clog2(REPEAT_DELAY) + 1;
  // A period longer than the delay falls back to reloading from zero.
  localparam int RELOAD = (REPEAT_PERIOD >= REPEAT_DELAY) ? 0 : REPEAT_DELAY - REPEAT_PERIOD;

  logic [N-1:0]  sync1, sync2, sample;
  logic [PW-1:0] pcnt;
  logic          tick;

  // NOTE: sync flops reset to INVERT so the logical sample reads 0 straight out of reset;
  // every sequential assignment uses <= so all flops update from pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync1 <= INVERT;
      sync2 <= INVERT;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  assign sample = sync2 ^ INVERT;
  assign tick   = (pcnt == PW'(PRESCALE - 1));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) pcnt <= '0;
    else          pcnt <= tick ? '0 : pcnt + PW'(1);
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;
    logic          level_q, rise_q, fall_q, press_q;
    logic          commit, rep;

    // commit: this tick completes the required run of differing samples
    assign commit = tick && (sample[i] != level_q) && (dcnt == DW'(DEBOUNCE_TICKS - 1));
    assign rep    = (REPEAT_EN != 0) && level_q && tick && !commit &&
                    (hcnt == HW'(REPEAT_DELAY - 1));

    always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
        dcnt    <= '0;
        hcnt    <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        press_q <= 1'b0;
      end else begin
        rise_q  <= commit &  sample[i];
        fall_q  <= commit & ~sample[i];
        press_q <= (commit & sample[i]) | rep;

        if (sample[i] == level_q) dcnt <= '0;
        else if (tick)            dcnt <= commit ? '0 : dcnt + DW'(1);

        if (commit) level_q <= sample[i];

        if (!level_q || commit) hcnt <= '0;
        else if (tick)          hcnt <= rep ? HW'(RELOAD) : hcnt + HW'(1);
      end
    end

    assign level[i] = level_q;
    assign rise[i]  = rise_q;
    assign fall[i]  = fall_q;
    assign press[i] = press_q;
  end

  // A press arriving with a clear wins, so no event is lost.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) sticky <= '0;
    else          sticky <= (sticky & ~clr) | press;
  end

  assign irq = |(sticky & irq_en);

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: two instances (repeat off / on) driven by shared stimulus and
// checked every cycle against a tick-counting behavioural model, plus directed literal checks.
module tb_key_conditioner;

  localparam int         P   = 4;
  localparam int         DT  = 3;
  localparam int         RD  = 5;
  localparam int         RP  = 2;
  localparam logic [2:0] INV = 3'b111;

  logic       HCLK    = 1'b0;
  logic       HRESETn = 1'b0;
  logic [2:0] raw_in  = 3'b111;
  logic [2:0] clr     = 3'b000;
  logic [2:0] irq_en  = 3'b000;

  logic [2:0] level_o  [2];
  logic [2:0] rise_o   [2];
  logic [2:0] fall_o   [2];
  logic [2:0] press_o  [2];
  logic [2:0] sticky_o [2];
  logic       irq_o    [2];

  int total = 0;
  int bad   = 0;

  always #5 HCLK = ~HCLK;

  key_conditioner #(.N(3), .INVERT(INV), .PRESCALE(P), .DEBOUNCE_TICKS(DT),
                    .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_a (
    .HCLK(HCLK), .HRESETn(HRESETn), .raw_in(raw_in), .clr(clr), .irq_en(irq_en),
    .level(level_o[0]), .rise(rise_o[0]), .fall(fall_o[0]), .press(press_o[0]),
    .sticky(sticky_o[0]), .irq(irq_o[0]));

  key_conditioner #(.N(3), .INVERT(INV), .PRESCALE(P), .DEBOUNCE_TICKS(DT),
                    .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_b (
    .HCLK(HCLK), .HRESETn(HRESETn), .raw_in(raw_in), .clr(clr), .irq_en(irq_en),
    .level(level_o[1]), .rise(rise_o[1]), .fall(fall_o[1]), .press(press_o[1]),
    .sticky(sticky_o[1]), .irq(irq_o[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #2;
    end
  endtask

  // Bounded wait for a rise (want_rise=1) or fall pulse on instance d, channel ch.
  task automatic wait_edge(input string name, input int d, input int ch, input bit want_rise,
                           input int limit, output int n);
    n = 0;
    while (n < limit && !(want_rise ? rise_o[d][ch] : fall_o[d][ch])) begin
      step(1);
      n++;
    end
    total++;
    if (n >= limit) begin
      bad++;
      $display("FAIL %s: no pulse after %0d cycles, required within %0d", name, n, limit);
    end
  endtask

  // ---------------- behavioural model ----------------
  // run: consecutive ticks the sample has disagreed with level; held: ticks spent pressed.
  typedef struct {
    int run;
    int held;
    bit lvl;
    bit rise;
    bit fall;
    bit press;
    bit sticky;
  } ch_t;

  ch_t        m [2][3];
  logic [2:0] sq1 = INV;
  logic [2:0] sq2 = INV;
  logic [2:0] ms;
  int         cyc = 0;
  bit         mtick, commit, rep;

  function automatic bit is_repeat(input int held);
    return (held >= RD) && ((held - RD) % RP == 0);
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin : model
    if (!HRESETn) begin
      for (int c = 0; c < 2; c++)
        for (int i = 0; i < 3; i++) m[c][i] = '{default: 0};
      sq1 = INV;
      sq2 = INV;
      cyc = 0;
    end else begin
      mtick = (cyc % P) == P - 1;
      cyc++;
      ms  = sq2 ^ INV;
      sq2 = sq1;
      sq1 = raw_in;
      for (int c = 0; c < 2; c++) begin
        for (int i = 0; i < 3; i++) begin
          m[c][i].sticky = (m[c][i].sticky && !clr[i]) || m[c][i].press;
          commit = 0;
          rep    = 0;
          if (ms[i] == m[c][i].lvl) m[c][i].run = 0;
          else if (mtick) begin
            m[c][i].run = m[c][i].run + 1;
            if (m[c][i].run == DT) begin
              commit      = 1;
              m[c][i].run = 0;
            end
          end
          if (!m[c][i].lvl || commit) m[c][i].held = 0;
          else if (mtick) begin
            m[c][i].held = m[c][i].held + 1;
            rep = (c == 1) && is_repeat(m[c][i].held);
          end
          m[c][i].rise  = commit && ms[i];
          m[c][i].fall  = commit && !ms[i];
          m[c][i].press = m[c][i].rise || rep;
          if (commit) m[c][i].lvl = ms[i];
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [2:0] el, er, ef, ep, es;

  always @(negedge HCLK) begin : compare
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 3; i++) begin
        el[i] = m[c][i].lvl;
        er[i] = m[c][i].rise;
        ef[i] = m[c][i].fall;
        ep[i] = m[c][i].press;
        es[i] = m[c][i].sticky;
      end
      check($sformatf("level%0d", c),  level_o[c],  el);
      check($sformatf("rise%0d", c),   rise_o[c],   er);
      check($sformatf("fall%0d", c),   fall_o[c],   ef);
      check($sformatf("press%0d", c),  press_o[c],  ep);
      check($sformatf("sticky%0d", c), sticky_o[c], es);
      check($sformatf("irq%0d", c),    irq_o[c],    |(es & irq_en));
    end
  end

  // ---------------- directed + random stimulus ----------------
  int n, cnt_a, cnt_b, cnt_r, cnt_f;
  int hold [3];

  initial begin
    // 1: reset with toggling inputs, then release idle
    for (int k = 0; k < 6; k++) begin
      raw_in = 3'($urandom);
      step(1);
      check("t1_rst_level", level_o[0], 3'b000);
      check("t1_rst_sticky", sticky_o[1], 3'b000);
    end
    raw_in = 3'b111;
    step(1);
    HRESETn = 1'b1;
    step(30);
    check("t1_idle_level", level_o[0], 3'b000);
    check("t1_idle_press", press_o[0], 3'b000);

    // 2: press / release channel 0
    irq_en = 3'b001;
    raw_in = 3'b110;
    wait_edge("t2_rise", 0, 0, 1'b1, 20, n);
    check("t2_latency_in_range", (n >= 11 && n <= 14), 1);
    check("t2_level", level_o[0][0], 1'b1);
    check("t2_press", press_o[0][0], 1'b1);
    step(1);
    check("t2_rise_width", rise_o[0][0], 1'b0);
    check("t2_sticky", sticky_o[0][0], 1'b1);
    check("t2_irq_on", irq_o[0], 1'b1);
    irq_en = 3'b000;
    #1;
    check("t2_irq_masked", irq_o[0], 1'b0);
    irq_en = 3'b001;
    raw_in = 3'b111;
    wait_edge("t2_fall", 0, 0, 1'b0, 20, n);
    check("t2_fall_level", level_o[0][0], 1'b0);
    check("t2_sticky_kept", sticky_o[0][0], 1'b1);
    clr = 3'b111;
    step(1);
    clr = 3'b000;
    step(20);

    // 3: short glitch ignored, longer low debounced into exactly one rise
    cnt_r = 0;
    cnt_f = 0;
    raw_in = 3'b101;
    for (int k = 0; k < 6; k++) begin step(1); cnt_r += int'(rise_o[0][1]); end
    raw_in = 3'b111;
    for (int k = 0; k < 20; k++) begin step(1); cnt_r += int'(rise_o[0][1]); end
    check("t3_glitch_no_rise", cnt_r, 0);
    check("t3_glitch_no_level", level_o[0][1], 1'b0);
    raw_in = 3'b101;
    for (int k = 0; k < 14; k++) begin step(1); cnt_r += int'(rise_o[0][1]); end
    raw_in = 3'b111;
    for (int k = 0; k < 40; k++) begin
      step(1);
      cnt_r += int'(rise_o[0][1]);
      cnt_f += int'(fall_o[0][1]);
    end
    check("t3_one_rise", cnt_r, 1);
    check("t3_one_fall", cnt_f, 1);
    clr = 3'b111;
    step(1);
    clr = 3'b000;
    step(10);

    // 4: auto-repeat on instance b, channel 0
    raw_in = 3'b110;
    wait_edge("t4_rise", 1, 0, 1'b1, 20, n);
    cnt_b = int'(press_o[1][0]);
    cnt_a = int'(press_o[0][0]);
    for (int k = 0; k < 20 * P; k++) begin
      step(1);
      cnt_b += int'(press_o[1][0]);
      cnt_a += int'(press_o[0][0]);
    end
    check("t4_repeat_presses", cnt_b, 9);
    check("t4_norepeat_presses", cnt_a, 1);
    raw_in = 3'b111;
    wait_edge("t4_fall", 1, 0, 1'b0, 20, n);
    check("t4_no_press_at_fall", press_o[1][0], 1'b0);
    cnt_b = 0;
    for (int k = 0; k < 40; k++) begin step(1); cnt_b += int'(press_o[1][0]); end
    check("t4_no_press_after_fall", cnt_b, 0);
    clr = 3'b111;
    step(1);
    clr = 3'b000;
    step(10);

    // 5: clear interplay and simultaneous channels
    irq_en = 3'b111;
    raw_in = 3'b001;
    wait_edge("t5_rise", 0, 2, 1'b1, 20, n);
    check("t5_both_rise", rise_o[0][1], 1'b1);
    check("t5_press2", press_o[0][2], 1'b1);
    clr = 3'b100;
    step(1);
    clr = 3'b000;
    check("t5_press_beats_clr", sticky_o[0][2], 1'b1);
    check("t5_sticky1", sticky_o[0][1], 1'b1);
    clr = 3'b010;
    step(1);
    clr = 3'b000;
    check("t5_sticky1_cleared", sticky_o[0][1], 1'b0);
    check("t5_irq_still", irq_o[0], 1'b1);
    clr = 3'b100;
    step(1);
    clr = 3'b000;
    check("t5_sticky2_cleared", sticky_o[0][2], 1'b0);
    check("t5_irq_drop", irq_o[0], 1'b0);
    raw_in = 3'b111;
    step(30);
    clr = 3'b111;
    step(1);
    clr = 3'b000;

    // 6: reset two ticks into a debounce, then a full debounce is needed again
    HRESETn = 1'b0;
    step(1);
    HRESETn = 1'b1;
    raw_in  = 3'b110;
    step(9);
    check("t6_no_level_yet", level_o[0][0], 1'b0);
    HRESETn = 1'b0;
    step(1);
    HRESETn = 1'b1;
    check("t6_no_pulse_on_release", rise_o[0][0], 1'b0);
    cnt_r = 0;
    for (int k = 0; k < 11; k++) begin step(1); cnt_r += int'(rise_o[0][0]); end
    check("t6_no_early_rise", cnt_r, 0);
    step(1);
    check("t6_rise_after_full", rise_o[0][0], 1'b1);
    raw_in = 3'b111;
    step(30);

    // random phase: mixed glitches, debounced changes, long holds, clears, resets
    for (int i = 0; i < 3; i++) hold[i] = 1;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 3; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          raw_in[i] = ~raw_in[i];
          hold[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(40, 120))
                                                : int'($urandom_range(1, 16));
        end
      end
      clr = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
      if ($urandom_range(0, 63) == 0) irq_en = 3'($urandom);
      HRESETn = ($urandom_range(0, 599) != 0);
      step(1);
    end
    HRESETn = 1'b1;
    clr     = 3'b000;
    step(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
